// File: rtl/counter_updown_sync_param.sv
// counter_updown_sync_param: parametrised synchronous up/down modulo counter
// with parallel load, combinational terminal count for cascading and a
// registered wrap flag.
// Optional build macro: COUNTER_SATURATE_EN -- counter saturates at the
// bounds instead of wrapping; wrap then flags a held-at-bound count attempt.
module counter_updown_sync_param #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    // Bound detection and out-of-range load clamp
    always_comb begin
        at_max       = (Q == MAX_VAL);
        at_zero      = (Q == '0);
        load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end

    // Terminal count: enables the next cascaded stage on the edge this one wraps
    always_comb begin
        tc = enable & (up_down ? at_max : at_zero);
    end

    // Next count and wrap flag; priority load > enable > hold (reset in the register)
    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = load_clamped;
        end else if (enable) begin
            if (up_down) begin
                if (at_max) begin
`ifdef COUNTER_SATURATE_EN
                    q_next    = MAX_VAL;
`else
                    q_next    = '0;
`endif
                    wrap_next = 1'b1;
                end else begin
                    q_next = Q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
                    q_next    = '0;
`else
                    q_next    = MAX_VAL;
`endif
                    wrap_next = 1'b1;
                end else begin
                    q_next = Q - WIDTH'(1);
                end
            end
        end
    end

    // Count and wrap registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_counter_updown_sync_param.sv
// Testbench for counter_updown_sync_param (WIDTH=4, MODULUS=10): directed
// scenarios plus randomized stimulus against an arithmetic reference model,
// and a two-stage cascade.
module tb_counter_updown_sync_param;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset, enable, up_down, load;
    logic [W-1:0] load_value;
    logic [W-1:0] Q;
    logic         tc, wrap;

    logic         c_reset, c_en;
    logic [W-1:0] c_q0, c_q1;
    logic         c_tc0, c_tc1, c_wrap0, c_wrap1;

    int checks = 0;
    int errors = 0;

    int m_q     = 0;
    bit m_w     = 1'b0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    counter_updown_sync_param #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .Q(Q), .tc(tc), .wrap(wrap)
    );

    counter_updown_sync_param #(.WIDTH(W), .MODULUS(M)) stage0 (
        .clk(clk), .reset(c_reset), .enable(c_en), .up_down(1'b1),
        .load(1'b0), .load_value('0), .Q(c_q0), .tc(c_tc0), .wrap(c_wrap0)
    );

    counter_updown_sync_param #(.WIDTH(W), .MODULUS(M)) stage1 (
        .clk(clk), .reset(c_reset), .enable(c_tc0), .up_down(1'b1),
        .load(1'b0), .load_value('0), .Q(c_q1), .tc(c_tc1), .wrap(c_wrap1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: plain modulo-M arithmetic on an integer count
    function automatic bit model_tc(input bit e, input bit ud);
        return e && (ud ? (m_q == M - 1) : (m_q == 0));
    endfunction

    task automatic model_update(input bit r, input bit l, input bit e, input bit ud, input int lv);
        if (r) begin
            m_q = 0;
            m_w = 1'b0;
        end else if (l) begin
            m_q = (lv >= M) ? M - 1 : lv;
            m_w = 1'b0;
        end else if (e) begin
`ifdef COUNTER_SATURATE_EN
            if (ud) begin
                m_w = (m_q == M - 1);
                m_q = (m_q == M - 1) ? m_q : m_q + 1;
            end else begin
                m_w = (m_q == 0);
                m_q = (m_q == 0) ? 0 : m_q - 1;
            end
`else
            if (ud) begin
                m_w = (m_q == M - 1);
                m_q = (m_q + 1) % M;
            end else begin
                m_w = (m_q == 0);
                m_q = (m_q - 1 + M) % M;
            end
`endif
        end else begin
            m_w = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, check tc before the edge and Q/wrap after it
    task automatic step(input bit r, input bit l, input bit e, input bit ud, input int lv);
        reset      = r;
        load       = l;
        enable     = e;
        up_down    = ud;
        load_value = W'(lv);
        #1;
        if (m_valid) check("tc", 32'(tc), 32'(model_tc(e, ud)));
        @(posedge clk);
        model_update(r, l, e, ud, lv);
        m_valid = 1'b1;
        #1;
        check("q", 32'(Q), 32'(m_q));
        check("wrap", 32'(wrap), 32'(m_w));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = '0;
        c_reset = 1'b1; c_en = 1'b0;

        // Reset, then count up through the wrap
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("reset_q", 32'(Q), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
`ifdef COUNTER_SATURATE_EN
        check("up12_q", 32'(Q), 32'd9);
`else
        check("up12_q", 32'(Q), 32'd2);
`endif

        // Load 3, count down through zero
        step(0, 1, 0, 0, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
`ifdef COUNTER_SATURATE_EN
        check("down5_q", 32'(Q), 32'd0);
`else
        check("down5_q", 32'(Q), 32'd8);
`endif

        // Load wins over enable; out-of-range load clamps
        step(0, 1, 1, 1, 7);
        check("load7_q", 32'(Q), 32'd7);
        step(0, 1, 1, 0, 14);
        check("load14_q", 32'(Q), 32'd9);
        step(0, 1, 0, 1, 15);
        check("load15_q", 32'(Q), 32'd9);

        // Reset beats load; disabled counter holds with tc low
        step(0, 1, 0, 1, 5);
        step(1, 1, 1, 1, 3);
        check("rst_load_q", 32'(Q), 32'd0);
        check("rst_load_wrap", 32'(wrap), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        check("hold_q", 32'(Q), 32'd0);
        check("hold_tc", 32'(tc), 32'd0);

        // Randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)));
        end

        // Two-stage cascade: 25 counts from reset
        @(posedge clk); #1;
        c_reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        c_reset = 1'b0;
        c_en    = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
        end
        c_en = 1'b0;
`ifdef COUNTER_SATURATE_EN
        check("casc_q0", 32'(c_q0), 32'd9);
        check("casc_q1", 32'(c_q1), 32'd9);
`else
        check("casc_q0", 32'(c_q0), 32'd5);
        check("casc_q1", 32'(c_q1), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
